sha256_ctrl: RTL and testbench
==============================

Name: sha256_ctrl

Overview:
Top-level sequencer for the single-block SHA256 accelerator.
- On a go request it latches the message length and starts gen_padded_onehot, then waits for the padded 512-bit block.
- It steps the compression core through init, 64 rounds and final H-add, then writes the 8 digest words to the output SRAM.
- Sits between the host go/done interface and the padder, round core and output SRAM.

Parameters:
MAX_MESSAGE_LENGTH, 55, maximum message length in characters (single 512-bit block).
OUT_ADDR_WIDTH, 3, output SRAM address width (8 digest words).
PAD_TIMEOUT, 1023, maximum cycles spent in PAD_WAIT before aborting.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
main_go_sig  in  1  start request; sampled only in IDLE.
msg_len  in  $clog2(MAX_MESSAGE_LENGTH)  message length in characters.
pad_go  out  1  one-cycle start pulse to padder.
pad_msg_len  out  $clog2(MAX_MESSAGE_LENGTH)  latched length to padder.
pad_rdy  in  1  padded block ready (level or pulse).
core_init  out  1  load H0 into working vars and W from pad register.
core_round_en  out  1  execute one round.
core_round_idx  out  6  current round, 0..63.
core_k  out  32  K constant for core_round_idx.
core_final  out  1  add working vars into H.
hash_sel  out  3  digest word select to core.
hash_word  in  32  selected digest word (combinational from core).
out_sram_en  out  1  output SRAM enable.
out_sram_write  out  1  output SRAM write strobe.
out_sram_addr  out  OUT_ADDR_WIDTH  output SRAM address.
out_sram_data  out  32  write data; combinational pass-through of hash_word.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle completion pulse.
error  out  1  one-cycle abort pulse.

Behaviour:
Reset
- reset=0 forces IDLE asynchronously.
- All registered outputs go to 0: pad_msg_len, core_round_idx, hash_sel and out_sram_addr are 0; all strobes and busy/done/error are 0.
- Reset asserted mid-operation aborts immediately; no done or error is produced.

FSM: IDLE, PAD_START, PAD_WAIT, INIT, ROUNDS, FINAL, WRITE, DONE.
- IDLE: on main_go_sig=1 with msg_len<=MAX_MESSAGE_LENGTH, latch msg_len into pad_msg_len and go to PAD_START. If msg_len>MAX_MESSAGE_LENGTH, pulse error, stay in IDLE and leave pad_msg_len unchanged.
- PAD_START: pad_go=1 for exactly one cycle; clear the timeout counter; go to PAD_WAIT. pad_rdy is ignored in this state.
- PAD_WAIT: pad_rdy=1 leads to INIT. If the timeout counter reaches PAD_TIMEOUT, pulse error and go to IDLE.
- INIT: core_init=1 for one cycle; core_round_idx=0.
- ROUNDS: core_round_en=1 for exactly 64 consecutive cycles, with core_round_idx running 0..63. After idx 63, go to FINAL; the index does not wrap.
- FINAL: core_final=1 for one cycle.
- WRITE: 8 cycles. out_sram_en=out_sram_write=1, out_sram_addr=hash_sel=0..7. out_sram_data=hash_word in the same cycle.
- DONE: done=1 for one cycle, then IDLE.

Rules
- main_go_sig is ignored outside IDLE and does not queue.
- A go held high restarts a new hash only after DONE→IDLE, one cycle later.
- core_k comes from a registered ROM lookup aligned with core_round_idx, so the ROM address is the next index.
- All outputs except out_sram_data are registered.

Latency, with go sampled at edge 0 and pad_rdy first high at edge P:
- pad_go at edge 1.
- core_init at edge P+1.
- Rounds at edges P+2..P+65.
- core_final at edge P+66.
- Writes at edges P+67..P+74.
- done at edge P+75.

Decomposition:
- Shared package sha256_pkg:
  - FSM state enum;
  - ROUND_COUNT=64;
  - DIGEST_WORDS=8;
  - WORD_WIDTH=32;
  - H0 constants.
- Sub-module sha256_k_rom: 64x32 registered ROM holding the K constants, addressed by the round counter.

Test Plan:
- Reset, then go with msg_len=55 and padder stub giving pad_rdy 3 cycles after pad_go → pad_go pulses once, pad_msg_len=55, exactly 64 round_en cycles with idx 0..63, core_k at idx0=0x428a2f98 and idx63=0xc67178f2, 8 writes to addr 0..7, done at P+75, busy low after.
- Go held high continuously → back-to-back hashes; second pad_go occurs 2 cycles after the first done; no go accepted while busy.
- msg_len=60 with go → error pulses for 1 cycle, busy stays 0, no pad_go.
- pad_rdy never asserted → error exactly PAD_TIMEOUT cycles after entering PAD_WAIT, then IDLE.
- reset driven low at round idx 30 → all outputs 0 immediately; after release, a new go completes normally with no stray done.
- Core stub returning hash_word=0xA5A50000+hash_sel → output SRAM contents 0xA5A50000..0xA5A50007 at addresses 0..7.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the single-block SHA256 accelerator.
//   - sequencer state encoding
//   - round / digest / word geometry
//   - SHA256 round constants K and initial hash H0
package sha256_pkg;

    localparam int ROUND_COUNT  = 64;
    localparam int DIGEST_WORDS = 8;
    localparam int WORD_WIDTH   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAD_START,
        S_PAD_WAIT,
        S_INIT,
        S_ROUNDS,
        S_FINAL,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [WORD_WIDTH-1:0] K_TABLE [ROUND_COUNT] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [WORD_WIDTH-1:0] H0 [DIGEST_WORDS] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Initial hash word lookup for the compression core.
    function automatic logic [WORD_WIDTH-1:0] h0_word(input logic [2:0] idx);
        return H0[idx];
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Registered 64x32 ROM of SHA256 round constants.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (output clears to 0)
//   addr_i  : round index to look up
//   k_o     : K[addr_i], one cycle after addr_i is presented
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [5:0]            addr_i,
    output logic [WORD_WIDTH-1:0] k_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_o <= '0;
        end else begin
            k_o <= K_TABLE[addr_i];
        end
    end

endmodule

// File: rtl/sha256_ctrl.sv
// Top-level sequencer for the single-block SHA256 accelerator.
// Accepts a host go, starts the padder, waits for the padded block, steps
// the compression core through init / 64 rounds / final add, then streams
// the 8 digest words into the output SRAM and pulses done.
//   clock, reset            : clock (rising) and async active-low reset
//   main_go_sig, msg_len    : host start request and message length
//   pad_go, pad_msg_len     : padder start pulse and latched length
//   pad_rdy                 : padded block available
//   core_*                  : compression core controls and round constant
//   hash_sel, hash_word     : digest word select / selected word from core
//   out_sram_*              : output SRAM write port
//   busy, done, error       : host status
module sha256_ctrl
    import sha256_pkg::*;
#(
    parameter  int MAX_MESSAGE_LENGTH = 55,
    parameter  int OUT_ADDR_WIDTH     = 3,
    parameter  int PAD_TIMEOUT        = 1023,
    localparam int LEN_W              = $clog2(MAX_MESSAGE_LENGTH),
    localparam int TO_W               = $clog2(PAD_TIMEOUT + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      main_go_sig,
    input  logic [LEN_W-1:0]          msg_len,
    output logic                      pad_go,
    output logic [LEN_W-1:0]          pad_msg_len,
    input  logic                      pad_rdy,
    output logic                      core_init,
    output logic                      core_round_en,
    output logic [5:0]                core_round_idx,
    output logic [WORD_WIDTH-1:0]     core_k,
    output logic                      core_final,
    output logic [2:0]                hash_sel,
    input  logic [WORD_WIDTH-1:0]     hash_word,
    output logic                      out_sram_en,
    output logic                      out_sram_write,
    output logic [OUT_ADDR_WIDTH-1:0] out_sram_addr,
    output logic [WORD_WIDTH-1:0]     out_sram_data,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    state_e                      state_q;
    logic                        pad_go_q, core_init_q, round_en_q, final_q;
    logic                        sram_we_q, busy_q, done_q, error_q;
    logic [LEN_W-1:0]            pad_msg_len_q;
    logic [5:0]                  round_idx_q;
    // rnd_q runs one step ahead of round_idx_q so the registered ROM output
    // lands in the same cycle as the index it belongs to.
    logic [5:0]                  rnd_q;
    logic [OUT_ADDR_WIDTH-1:0]   wr_q;
    logic [OUT_ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]                  hash_sel_q;
    logic [TO_W-1:0]             to_q;

    sha256_k_rom u_k_rom (
        .clk_i  (clock),
        .rst_ni (reset),
        .addr_i (rnd_q),
        .k_o    (core_k)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pad_go_q      <= 1'b0;
            core_init_q   <= 1'b0;
            round_en_q    <= 1'b0;
            final_q       <= 1'b0;
            sram_we_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            pad_msg_len_q <= '0;
            round_idx_q   <= '0;
            rnd_q         <= '0;
            wr_q          <= '0;
            addr_q        <= '0;
            hash_sel_q    <= '0;
            to_q          <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted by the state below.
            pad_go_q    <= 1'b0;
            core_init_q <= 1'b0;
            round_en_q  <= 1'b0;
            final_q     <= 1'b0;
            sram_we_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (main_go_sig) begin
                        if (int'(msg_len) <= MAX_MESSAGE_LENGTH) begin
                            pad_msg_len_q <= msg_len;
                            busy_q        <= 1'b1;
                            state_q       <= S_PAD_START;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_PAD_START: begin
                    pad_go_q <= 1'b1;
                    to_q     <= '0;
                    state_q  <= S_PAD_WAIT;
                end
                S_PAD_WAIT: begin
                    if (pad_rdy) begin
                        state_q <= S_INIT;
                    end else if (to_q == TO_W'(PAD_TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                S_INIT: begin
                    core_init_q <= 1'b1;
                    round_idx_q <= '0;
                    rnd_q       <= '0;
                    state_q     <= S_ROUNDS;
                end
                S_ROUNDS: begin
                    round_en_q  <= 1'b1;
                    round_idx_q <= rnd_q;
                    // Hold at the last index so core_k stays aligned with it.
                    if (rnd_q == 6'(ROUND_COUNT - 1)) begin
                        state_q <= S_FINAL;
                    end else begin
                        rnd_q <= rnd_q + 6'd1;
                    end
                end
                S_FINAL: begin
                    final_q <= 1'b1;
                    wr_q    <= '0;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    sram_we_q  <= 1'b1;
                    addr_q     <= wr_q;
                    hash_sel_q <= 3'(wr_q);
                    if (wr_q == OUT_ADDR_WIDTH'(DIGEST_WORDS - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        wr_q <= wr_q + OUT_ADDR_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pad_go         = pad_go_q;
    assign pad_msg_len    = pad_msg_len_q;
    assign core_init      = core_init_q;
    assign core_round_en  = round_en_q;
    assign core_round_idx = round_idx_q;
    assign core_final     = final_q;
    assign hash_sel       = hash_sel_q;
    assign out_sram_en    = sram_we_q;
    assign out_sram_write = sram_we_q;
    assign out_sram_addr  = addr_q;
    // Core drives hash_word combinationally from hash_sel, so data lines up
    // with the registered address without an extra stage.
    assign out_sram_data  = hash_word;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_sha256_ctrl.sv
// Scoreboard bench for sha256_ctrl: stimulus pushes timed expected events,
// a negedge monitor pops and compares them against DUT strobes.
module tb_sha256_ctrl;

    localparam int MAXL = 55;
    localparam int PT   = 1023;
    localparam int LW   = $clog2(MAXL);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          main_go_sig = 1'b0;
    logic          pad_rdy = 1'b0;
    logic [LW-1:0] msg_len = '0;
    logic          pad_go, core_init, core_round_en, core_final;
    logic          out_sram_en, out_sram_write, busy, done, error;
    logic [LW-1:0] pad_msg_len;
    logic [5:0]    core_round_idx;
    logic [31:0]   core_k, hash_word, out_sram_data;
    logic [2:0]    hash_sel, out_sram_addr;
    logic [31:0]   hw_base = 32'hA5A50000;
    logic [63:0]   outvec;

    // Core stub: digest word = base + selector.
    assign hash_word = hw_base + {29'b0, hash_sel};
    assign outvec = {5'b0, pad_go, pad_msg_len, core_init, core_round_en, core_round_idx,
                     core_k, core_final, hash_sel, out_sram_en, out_sram_write,
                     out_sram_addr, busy, done, error};

    sha256_ctrl dut (
        .clock(clock), .reset(reset), .main_go_sig(main_go_sig), .msg_len(msg_len),
        .pad_go(pad_go), .pad_msg_len(pad_msg_len), .pad_rdy(pad_rdy),
        .core_init(core_init), .core_round_en(core_round_en),
        .core_round_idx(core_round_idx), .core_k(core_k), .core_final(core_final),
        .hash_sel(hash_sel), .hash_word(hash_word), .out_sram_en(out_sram_en),
        .out_sram_write(out_sram_write), .out_sram_addr(out_sram_addr),
        .out_sram_data(out_sram_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {E_PADGO, E_INIT, E_ROUND, E_FINAL, E_WRITE, E_DONE, E_ERROR} ekind_e;
    typedef struct {
        int          t;
        ekind_e      kind;
        logic [31:0] a;
        logic [31:0] b;
    } evt_t;

    evt_t        sb[$];
    logic [31:0] kref[64];
    int          ntests = 0;
    int          nfail  = 0;
    int          last_len = 0;

    // K[i] = first 32 fractional bits of the cube root of the i-th prime.
    function automatic logic [31:0] cube_frac(input int pr);
        real x, f;
        x = $pow(real'(pr), 1.0 / 3.0);
        x = x - (x * x * x - real'(pr)) / (3.0 * x * x);
        f = x - $floor(x);
        return 32'(longint'($floor(f * 4294967296.0)));
    endfunction

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push(input int t, input ekind_e k, input logic [31:0] a, input logic [31:0] b);
        evt_t e;
        e.t = t; e.kind = k; e.a = a; e.b = b;
        sb.push_back(e);
    endfunction

    function automatic void observe(input ekind_e k, input logic [31:0] a, input logic [31:0] b);
        evt_t e;
        ntests++;
        if (sb.size() == 0 || sb[0].t != cyc) begin
            nfail++;
            $display("FAIL unexpected %s at cycle %0d a=%h b=%h", k.name(), cyc, a, b);
            return;
        end
        e = sb.pop_front();
        if (e.kind != k || e.a !== a || e.b !== b) begin
            nfail++;
            $display("FAIL event at cycle %0d: got %s a=%h b=%h, expected %s a=%h b=%h",
                     cyc, k.name(), a, b, e.kind.name(), e.a, e.b);
        end
        if (k == E_ROUND && a == 32'd0)  check("k_idx0", {32'b0, b}, 64'h428a2f98);
        if (k == E_ROUND && a == 32'd63) check("k_idx63", {32'b0, b}, 64'hc67178f2);
    endfunction

    // Monitor
    always @(negedge clock) begin
        if (reset) begin
            while (sb.size() > 0 && sb[0].t < cyc) begin
                ntests++;
                nfail++;
                $display("FAIL missed %s due at cycle %0d (now %0d)", sb[0].kind.name(), sb[0].t, cyc);
                void'(sb.pop_front());
            end
            if (pad_go)        observe(E_PADGO, 32'(pad_msg_len), 32'h0);
            if (core_init)     observe(E_INIT, 32'(core_round_idx), 32'h0);
            if (core_round_en) observe(E_ROUND, 32'(core_round_idx), core_k);
            if (core_final)    observe(E_FINAL, 32'h0, 32'h0);
            if (out_sram_en || out_sram_write)
                observe(E_WRITE, {24'b0, out_sram_en, out_sram_write, hash_sel, out_sram_addr}, out_sram_data);
            if (done)          observe(E_DONE, 32'h0, 32'h0);
            if (error)         observe(E_ERROR, 32'h0, 32'h0);
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Expected event stream for a hash with go sampled at edge g and pad_rdy
    // first seen d edges after pad_go.
    task automatic push_hash(input int g, input int d, input int len);
        int p;
        p = g + 1 + d;
        push(g + 1, E_PADGO, len, 0);
        push(p + 1, E_INIT, 0, 0);
        for (int i = 0; i < 64; i++) push(p + 2 + i, E_ROUND, i, kref[i]);
        push(p + 66, E_FINAL, 0, 0);
        for (int j = 0; j < 8; j++) push(p + 67 + j, E_WRITE, 32'hC0 | (j << 3) | j, hw_base + j);
        push(p + 75, E_DONE, 0, 0);
    endtask

    // Padder stub; optional early pulse lands on PAD_START and must be ignored.
    task automatic drive_rdy(input int g, input int d, input bit early);
        int p, h;
        p = g + 1 + d;
        if (early) begin
            wait_cyc(g); pad_rdy = 1'b1;
            wait_cyc(g + 1); pad_rdy = 1'b0;
        end
        wait_cyc(p - 1); pad_rdy = 1'b1;
        h = $urandom_range(1, 3);
        wait_cyc(p - 1 + h); pad_rdy = 1'b0;
    endtask

    task automatic single(input int len, input int d, input bit early);
        int g;
        g = cyc + 1;
        msg_len = LW'(len); main_go_sig = 1'b1;
        push_hash(g, d, len);
        wait_cyc(g); main_go_sig = 1'b0;
        check("busy_on", {63'b0, busy}, 64'd1);
        drive_rdy(g, d, early);
        wait_cyc(g + 1 + d + 76);
        check("busy_after", {63'b0, busy}, 64'd0);
        last_len = len;
    endtask

    task automatic bad_len(input int len);
        int g;
        g = cyc + 1;
        msg_len = LW'(len); main_go_sig = 1'b1;
        push(g, E_ERROR, 0, 0);
        wait_cyc(g); main_go_sig = 1'b0;
        check("badlen_busy", {63'b0, busy}, 64'd0);
        check("badlen_keep_len", 64'(pad_msg_len), 64'(last_len));
        wait_cyc(g + 3);
        check("badlen_busy_later", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int n, g1, g2, d1, d2, l1, l2, p;
        bit isp;
        n = 0;
        for (int c = 2; n < 64; c++) begin
            isp = 1'b1;
            for (int q = 2; q * q <= c; q++) if (c % q == 0) isp = 1'b0;
            if (isp) begin kref[n] = cube_frac(c); n++; end
        end

        #1 reset = 1'b0;
        #1 check("rst_init", outvec, 64'd0);
        wait_cyc(3); reset = 1'b1;
        wait_cyc(5);

        // Directed: max length, pad_rdy 3 cycles after pad_go.
        single(55, 3, 1'b0);

        // Randomized single hashes.
        for (int r = 0; r < 3; r++) begin
            wait_cyc(cyc + $urandom_range(1, 4));
            hw_base = $urandom;
            single($urandom_range(0, MAXL), $urandom_range(2, 6), 1'($urandom_range(0, 1)));
        end

        // Go held high: back-to-back hashes.
        wait_cyc(cyc + 2);
        l1 = $urandom_range(0, MAXL); l2 = $urandom_range(0, MAXL);
        d1 = $urandom_range(1, 5);   d2 = $urandom_range(1, 5);
        g1 = cyc + 1;
        msg_len = LW'(l1); main_go_sig = 1'b1;
        push_hash(g1, d1, l1);
        wait_cyc(g1); msg_len = LW'(l2);
        drive_rdy(g1, d1, 1'b0);
        g2 = g1 + 1 + d1 + 76;
        push_hash(g2, d2, l2);
        wait_cyc(g2); main_go_sig = 1'b0;
        drive_rdy(g2, d2, 1'b0);
        wait_cyc(g2 + 1 + d2 + 76);
        check("b2b_busy_after", {63'b0, busy}, 64'd0);
        last_len = l2;

        // Over-length requests.
        wait_cyc(cyc + 2);
        bad_len(60);
        bad_len($urandom_range(MAXL + 1, 63));

        // Padder never responds.
        wait_cyc(cyc + 2);
        l1 = $urandom_range(0, MAXL);
        g1 = cyc + 1;
        msg_len = LW'(l1); main_go_sig = 1'b1;
        push(g1 + 1, E_PADGO, l1, 0);
        push(g1 + 1 + PT, E_ERROR, 0, 0);
        wait_cyc(g1); main_go_sig = 1'b0;
        wait_cyc(g1 + PT);
        check("to_busy_before", {63'b0, busy}, 64'd1);
        wait_cyc(g1 + PT + 1);
        check("to_busy_after", {63'b0, busy}, 64'd0);
        last_len = l1;
        wait_cyc(cyc + 2);
        single($urandom_range(0, MAXL), 2, 1'b0);

        // Reset during round 30, then a clean hash.
        wait_cyc(cyc + 2);
        l1 = $urandom_range(0, MAXL); d1 = $urandom_range(1, 4);
        g1 = cyc + 1;
        msg_len = LW'(l1); main_go_sig = 1'b1;
        push_hash(g1, d1, l1);
        wait_cyc(g1); main_go_sig = 1'b0;
        drive_rdy(g1, d1, 1'b0);
        p = g1 + 1 + d1;
        wait_cyc(p + 2 + 30);
        #2 reset = 1'b0;
        sb.delete();
        #1 check("rst_mid", outvec, 64'd0);
        wait_cyc(cyc + 3);
        reset = 1'b1;
        last_len = 0;
        wait_cyc(cyc + 2);
        hw_base = 32'hA5A50000;
        single($urandom_range(0, MAXL), $urandom_range(1, 6), 1'b0);

        wait_cyc(cyc + 10);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
